// File: rtl/dff_capture_fifo.sv
// dff_capture_fifo: first-word-fall-through capture FIFO placed behind the
// DFF stage. Words are buffered and handed to the consumer over a
// valid/ready handshake. Dropped words set a sticky overflow flag.
// Optional feature macro: DFF_CAP_DROP_CNT_EN adds a saturating 16-bit
// drop counter on the drop_cnt port.
module dff_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           inp,
    input  logic                       inp_valid,
    output logic [WIDTH-1:0]           outp,
    output logic                       outp_valid,
    input  logic                       outp_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
`ifdef DFF_CAP_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_next;
    logic             head_load;
    logic             ovf_q;
    logic             pop;
    logic             push;
    logic             drop;

`ifdef DFF_CAP_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating increment so a long overflow burst never wraps back to 0.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign outp_valid = !empty;
    assign count      = count_q;
    assign outp       = head_q;
    assign overflow   = ovf_q;

    assign pop  = outp_valid && outp_ready;
    assign push = inp_valid && (!full || pop);
    assign drop = inp_valid && full && !pop;

    // Next occupancy, next read pointer and the word that becomes the head.
    // The head is kept in a register so it reads 0 after reset and holds the
    // last popped word while empty. When the slot about to become the head
    // is being written this same edge, the incoming word is bypassed.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CNT_W'(1);
            2'b01:   count_next = count_q - CNT_W'(1);
            default: count_next = count_q;
        endcase
        rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        head_next = (push && (wr_ptr == rd_next)) ? inp : mem[rd_next];
        head_load = (push || pop) && (count_next != '0);
    end

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= inp;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_next;
            count_q <= count_next;
            if (head_load) begin
                head_q <= head_next;
            end
        end
    end

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef DFF_CAP_DROP_CNT_EN
    // Drop counter; a drop coinciding with a clear restarts the count at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (ovf_clr) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: doc/dff_capture_fifo.md
# dff_capture_fifo

Downstream capture stage for the `dut` flip-flop. It accepts the registered `outp` stream of the DFF as its `inp` and buffers the words in a first-word-fall-through FIFO. The buffered words are presented to the consumer, the output monitor or a later pipeline stage, through a valid/ready handshake. Overflow of the buffer is reported through a sticky flag, and an optional counter records how many words were dropped.

## Interface
- `WIDTH`, default 8: data word width, must be at least 1.
- `DEPTH`, default 8: number of FIFO entries, a power of two with a minimum of 2.
- `clk`  input  1: the single clock; all state is updated on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `inp`  input  WIDTH: data word from the DFF `outp`.
- `inp_valid`  input  1: a push is requested this cycle.
- `outp`  output  WIDTH: the word at the FIFO head.
- `outp_valid`  output  1: the head word is valid; equal to `!empty`.
- `outp_ready`  input  1: the consumer accepts the head word.
- `count`  output  $clog2(DEPTH)+1: number of stored entries, from 0 to DEPTH.
- `full`  output  1: asserted when `count == DEPTH`.
- `empty`  output  1: asserted when `count == 0`.
- `overflow`  output  1: sticky flag marking that a word was dropped.
- `ovf_clr`  input  1: synchronous clear of `overflow`, and of `drop_cnt` when that port is compiled in.
- `drop_cnt`  output  16: number of dropped words. This port exists only when `DFF_CAP_DROP_CNT_EN` is defined.

## Operation
- Pop and push conditions:
  - `pop = outp_valid && outp_ready`.
  - `push = inp_valid && (!full || pop)`.
- Storage is a DEPTH-entry array with write and read pointers of width $clog2(DEPTH). Both pointers wrap modulo DEPTH. Occupancy is tracked by `count`, not derived from the pointers.
- On `push`, `inp` is written at the write pointer and the write pointer increments. On `pop`, the read pointer increments.
- `count` update rule:
  - increments by 1 on push only;
  - decrements by 1 on pop only;
  - is unchanged when push and pop occur together or when neither occurs.
- `outp` is the array entry at the read pointer, so the FIFO is first-word fall-through.
  - When empty, `outp` holds the last value read, or 0 after reset.
  - A consumer must not sample `outp` while `outp_valid` is low.
- Full with simultaneous pop: the push is accepted and `count` stays at DEPTH. No drop occurs.
- Empty with `inp_valid` high: the push is accepted. No pop happens in that cycle because `outp_valid` is 0.
- Drop:
  - A drop occurs when `inp_valid && full && !pop`.
  - The word is discarded; pointers and `count` are unchanged.
  - `overflow` is set at the next edge.
- Clearing the overflow flag:
  - `ovf_clr` clears `overflow` at the next edge.
  - If a drop occurs in the same cycle as `ovf_clr`, set wins and `overflow` remains 1.
- `outp_ready` asserted while empty has no effect.
- Reset, asserted asynchronously at any time:
  - pointers, `count`, `outp` and `overflow` go to 0, along with `drop_cnt` when compiled in;
  - `empty` becomes 1, and `full` and `outp_valid` become 0;
  - any in-flight data is lost.

## Timing
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `outp` with `outp_valid` high after edge N, and can be popped in the cycle that follows.
- A pop at edge N presents the next entry on `outp` after edge N. Back-to-back pops therefore sustain 1 word per cycle.
- `count`, `full`, `empty` and `overflow` are registered and change only at edges, or on an asynchronous reset.
- There is no combinational path from `inp_valid` to any output. The only combinational input-to-input dependency is `outp_ready` → `push` acceptance, which applies when the FIFO is full.
- Reset deassertion is synchronized externally. The first push may occur on the first edge after `rst_n` rises.

## Configuration
- `DFF_CAP_DROP_CNT_EN` defined:
  - the `drop_cnt` port and its 16-bit counter are present;
  - the counter increments on every drop and saturates at 16'hFFFF;
  - `ovf_clr` resets it to 0;
  - if a drop occurs in the same cycle as `ovf_clr`, `drop_cnt` becomes 1.
- `DFF_CAP_DROP_CNT_EN` undefined: the port and counter are absent. `overflow` behaves identically in both cases.

## Test plan
- Reset → check all outputs: `count` = 0, `empty` = 1, `full` = 0, `outp_valid` = 0, `overflow` = 0, `outp` = 0. Then assert `rst_n` = 0 mid-stream with 3 entries stored → `count` = 0 immediately, without waiting for a clock edge.
- Fill and drain with DEPTH = 8 and `outp_ready` = 0:
  - push 8'h01 through 8'h08 on consecutive cycles → `full` = 1, `count` = 8;
  - then hold `outp_ready` = 1 → `outp` reads 01..08 on consecutive cycles, `empty` = 1 after the 8th pop.
- Wrap-around: push and pop 20 words continuously with `inp` = i → output order is exactly 0..19, `count` never exceeds 1, and the pointers wrap twice.
- Full with simultaneous push and pop: with `full` = 1, `outp_ready` = 1 and push 8'hAA → no drop, `count` stays 8, `overflow` = 0, and 8'hAA pops 8 cycles later.
- Overflow:
  - with `full` = 1 and `outp_ready` = 0, push 3 words → `overflow` = 1 and contents unchanged; `drop_cnt` = 3 when compiled in;
  - `ovf_clr` together with a 4th drop → `overflow` = 1 and `drop_cnt` = 1;
  - `ovf_clr` alone → both read 0.
- DFF chain in the top-level bench: drive the `dut` `inp` with 5, 9, 12 on consecutive cycles and tie `inp_valid` = 1 → the FIFO delivers 5, 9, 12 in order, with 1 cycle of DFF latency plus 1 cycle of FIFO latency.
